uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Transmit-side frame sequencer for the UART.
- Accepts a parallel byte through a valid/ready handshake and drives the load/shift controls of the transmit shift register (piso).
- Muxes start, data, optional parity and stop bits onto the serial line.
- Runs on the bit-rate clock tx_clk: one tx_clk cycle per line bit.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (from uart_params.vh, 8), data bits per frame.
- STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.

Ports:
- tx_clk  in  1  bit-rate clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_WIDTH  byte to send; sampled on handshake.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  controller can accept a byte.
- piso_load  out  1  load strobe to the shift register.
- piso_shift  out  1  shift strobe to the shift register.
- piso_data  out  DATA_WIDTH  parallel data to the shift register.
- piso_serial  in  1  serial_out returned from the shift register.
- tx_line  out  1  UART serial line; idles high.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse on the last stop-bit cycle.

Behaviour:
- Clocking and reset: one clock, tx_clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, bit_cnt=0, stop_cnt=0, parity_reg=0.
  - Resulting outputs: tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, piso_load=0, piso_shift=0.
- Reset mid-frame: the line returns high immediately (asynchronous), with no partial stop bit. The next frame starts clean from IDLE.
- FSM states: IDLE, START, DATA, PARITY (only when the feature is enabled), STOP.
- IDLE:
  - tx_ready=1, tx_line=1.
  - piso_load = tx_valid (combinational). piso_data = tx_data (combinational passthrough).
  - On tx_valid=1 at a rising edge: go to START; capture the parity of tx_data.
- START (1 cycle):
  - tx_line=0, piso_shift=1, so the shift register presents bit0 in the next cycle.
  - Go to DATA; bit_cnt=0.
- DATA (DATA_WIDTH cycles):
  - tx_line = piso_serial, sending data LSB first.
  - piso_shift=1 while bit_cnt < DATA_WIDTH-1; bit_cnt increments each cycle.
  - When bit_cnt = DATA_WIDTH-1: go to PARITY if enabled, else STOP; stop_cnt=0.
- Shift-count rule: exactly DATA_WIDTH piso_shift pulses per frame (1 in START, DATA_WIDTH-1 in DATA).
- PARITY (1 cycle): tx_line = parity_reg; go to STOP.
- STOP (STOP_BITS cycles):
  - tx_line=1.
  - tx_done=1 when stop_cnt = STOP_BITS-1; go to IDLE on that cycle.
- Output timing:
  - tx_busy = (state != IDLE).
  - tx_ready = (state == IDLE); no acceptance during a frame.
  - tx_line, tx_ready, tx_busy, tx_done, piso_load, piso_shift are combinational decodes of state/counters/inputs, glitch-free at the bit boundary.
- Frame length: 1 + DATA_WIDTH + P + STOP_BITS cycles, where P is 1 with parity enabled, else 0.
- Back-to-back frames: the minimum handshake period is frame length + 1 cycle, because the IDLE cycle carries the accept.
- tx_valid deasserted in IDLE: remain in IDLE, line high, no strobes.
- tx_data changing after acceptance: ignored; the frame uses the loaded value.
- piso_load and piso_shift are never high in the same cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - The PARITY state exists.
  - parity_reg = XOR of tx_data, captured at accept (even parity).
  - The parity bit is sent after the data bits.
- Undefined:
  - No PARITY state and no parity register; DATA goes directly to STOP.
  - Frame = 1 + DATA_WIDTH + STOP_BITS cycles.

Test Plan:
- Reset, then hold tx_valid=0 for 20 cycles → tx_line=1, tx_ready=1, no load/shift strobes.
- tx_data=8'hA5, STOP_BITS=1, parity off → piso_load pulse at accept. Line then reads 0,1,0,1,0,0,1,0,1,1 over 10 cycles. tx_done is high on cycle 10; tx_ready returns on cycle 11.
- Same frame with UART_TX_PARITY_EN → line reads 0,1,0,1,0,0,1,0,1,0,1; the parity bit is 0 (four ones). tx_done is high on cycle 11.
- tx_valid held high with 8'h01 then 8'hFF, STOP_BITS=2 → two frames, each 11 cycles, separated by exactly 1 high IDLE cycle; 8 shift pulses per frame.
- rst_n asserted low in the 4th DATA cycle → tx_line=1 and tx_busy=0 immediately. A following 8'h3C frame is correct: 0,0,0,1,1,1,1,0,0,1.
- tx_data changed on every cycle during the frame → transmitted bits match the accepted value only.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between a transmit client and the UART transmit sequencer.
// The client (master) presents tx_data with tx_valid; the sequencer (slave)
// raises tx_ready while it is able to accept a byte.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit-side UART frame sequencer.
//
// Accepts a byte over the uart_tx_ctrl_if handshake, drives the load/shift
// strobes of an external parallel-in/serial-out shift register and muxes the
// start bit, the serial data returned by that register, an optional parity
// bit and the stop bit(s) onto tx_line. One tx_clk cycle equals one line bit.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after the data bits. Without it there is no PARITY state and no parity
// register, and a frame is 1 + DATA_WIDTH + STOP_BITS cycles long.
//
// Shift register contract: piso_load copies piso_data into the register;
// each piso_shift moves the next LSB onto piso_serial. The first shift is
// issued in START so bit0 is on piso_serial during the first DATA cycle.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_tx_ctrl #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int STOP_BITS  = 1            // 1 or 2
) (
    input  logic                  tx_clk,
    input  logic                  rst_n,
    uart_tx_ctrl_if.slave         tx_if,
    output logic                  piso_load,
    output logic                  piso_shift,
    output logic [DATA_WIDTH-1:0] piso_data,
    input  logic                  piso_serial,
    output logic                  tx_line,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic             stop_cnt_reg, stop_cnt_next;
    logic             ready_int;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    // State and counter registers; reset returns the line to idle at once.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the accepted byte, held for the whole frame.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

    // Next-state logic and combinational output decode of the frame sequencer.
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        tx_line       = 1'b1;
        ready_int     = 1'b0;
        piso_load     = 1'b0;
        piso_shift    = 1'b0;
        tx_done       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                ready_int = 1'b1;
                // The accept cycle loads the shift register directly.
                piso_load = tx_if.tx_valid;
                if (tx_if.tx_valid) begin
                    state_next  = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^tx_if.tx_data;
`endif
                end
            end

            S_START: begin
                tx_line      = 1'b0;
                piso_shift   = 1'b1;
                bit_cnt_next = '0;
                state_next   = S_DATA;
            end

            S_DATA: begin
                tx_line = piso_serial;
                if (bit_cnt_reg == LAST_BIT) begin
                    // Last data bit is already on piso_serial: no more shifts.
                    stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
                    state_next    = S_PARITY;
`else
                    state_next    = S_STOP;
`endif
                end else begin
                    piso_shift   = 1'b1;
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_line    = parity_reg;
                state_next = S_STOP;
            end
`endif

            S_STOP: begin
                tx_line = 1'b1;
                if (stop_cnt_reg == LAST_STOP) begin
                    tx_done    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    stop_cnt_next = stop_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign tx_busy        = (state_reg != S_IDLE);
    assign tx_if.tx_ready = ready_int;
    assign piso_data      = tx_if.tx_data;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: two instances (one and two stop bits), each with
// a behavioural shift register, checked against a bit-level frame model.
`timescale 1ns/1ps

module tb_uart_tx_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic tx_clk = 1'b0;
    logic rst_n  = 1'b0;

    logic [1:0]    valid_drv;
    logic [DW-1:0] data_drv    [2];
    logic [1:0]    load_w, shift_w, serial_w, line_w, busy_w, done_w, ready_w;
    logic [DW-1:0] piso_data_w [2];

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) if0 ();
    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) if1 ();

    assign if0.tx_valid = valid_drv[0];
    assign if0.tx_data  = data_drv[0];
    assign ready_w[0]   = if0.tx_ready;
    assign if1.tx_valid = valid_drv[1];
    assign if1.tx_data  = data_drv[1];
    assign ready_w[1]   = if1.tx_ready;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) u_dut1 (
        .tx_clk      (tx_clk),
        .rst_n       (rst_n),
        .tx_if       (if0),
        .piso_load   (load_w[0]),
        .piso_shift  (shift_w[0]),
        .piso_data   (piso_data_w[0]),
        .piso_serial (serial_w[0]),
        .tx_line     (line_w[0]),
        .tx_busy     (busy_w[0]),
        .tx_done     (done_w[0])
    );

    uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(2)) u_dut2 (
        .tx_clk      (tx_clk),
        .rst_n       (rst_n),
        .tx_if       (if1),
        .piso_load   (load_w[1]),
        .piso_shift  (shift_w[1]),
        .piso_data   (piso_data_w[1]),
        .piso_serial (serial_w[1]),
        .tx_line     (line_w[1]),
        .tx_busy     (busy_w[1]),
        .tx_done     (done_w[1])
    );

    // Behavioural shift registers: each shift moves the next LSB to the output.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_piso
            logic [DW-1:0] sr;
            logic          so;
            always @(posedge tx_clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                    so <= 1'b1;
                end else if (load_w[gi]) begin
                    sr <= piso_data_w[gi];
                end else if (shift_w[gi]) begin
                    so <= sr[0];
                    sr <= sr >> 1;
                end
            end
            assign serial_w[gi] = so;
        end
    endgenerate

    always #5 tx_clk = ~tx_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int stop_bits(input int idx);
        return (idx == 0) ? 1 : 2;
    endfunction

    function automatic int frame_len(input int idx);
        return 1 + DW + PAR + stop_bits(idx);
    endfunction

    // Line value k cycles after acceptance: start, data LSB first, parity, stops.
    function automatic logic exp_bit(input logic [DW-1:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= DW) return d[k-1];
        if (PAR == 1 && k == DW + 1) return ^d;
        return 1'b1;
    endfunction

    // Idle cycles with tx_valid low; called on a falling edge.
    task automatic idle_cycles(input int idx, input int n);
        valid_drv[idx] = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("idle_line",  line_w[idx],  1);
            check("idle_ready", ready_w[idx], 1);
            check("idle_busy",  busy_w[idx],  0);
            check("idle_load",  load_w[idx],  0);
            check("idle_shift", shift_w[idx], 0);
            check("idle_done",  done_w[idx],  0);
            @(negedge tx_clk);
        end
    endtask

    // One full frame starting in an IDLE cycle; called on a falling edge.
    task automatic send_frame(input int idx, input logic [DW-1:0] d, input bit scramble,
                              input bit hold_valid, input logic [DW-1:0] next_d);
        int flen;
        int shifts;
        flen = frame_len(idx);
        valid_drv[idx] = 1'b1;
        data_drv[idx]  = d;
        #1;
        check("acc_ready", ready_w[idx], 1);
        check("acc_line",  line_w[idx],  1);
        check("acc_busy",  busy_w[idx],  0);
        check("acc_load",  load_w[idx],  1);
        check("acc_shift", shift_w[idx], 0);
        check("acc_data",  piso_data_w[idx], d);
        @(negedge tx_clk);
        if (!hold_valid) valid_drv[idx] = 1'b0;
        shifts = 0;
        for (int k = 0; k < flen; k++) begin
            if (scramble) data_drv[idx] = DW'($urandom);
            if (hold_valid && k == flen - 1) data_drv[idx] = next_d;
            #1;
            check("line",  line_w[idx],  exp_bit(d, k));
            check("busy",  busy_w[idx],  1);
            check("ready", ready_w[idx], 0);
            check("done",  done_w[idx],  (k == flen - 1) ? 1 : 0);
            check("load",  load_w[idx],  0);
            if (shift_w[idx]) shifts++;
            @(negedge tx_clk);
        end
        check("shift_cnt", shifts, DW);
        $display("frame inst=%0d data=%02h len=%0d scramble=%0d", idx, d, flen, scramble);
    endtask

    initial begin
        logic [DW-1:0] d;
        int            idx;
        valid_drv   = 2'b00;
        data_drv[0] = '0;
        data_drv[1] = '0;

        // Reset state.
        repeat (2) @(negedge tx_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_line",  line_w[i],  1);
            check("rst_ready", ready_w[i], 1);
            check("rst_busy",  busy_w[i],  0);
            check("rst_done",  done_w[i],  0);
        end
        @(negedge tx_clk);
        rst_n = 1'b1;
        @(negedge tx_clk);

        // Long idle with tx_valid low.
        idle_cycles(0, 20);
        idle_cycles(1, 2);

        // Directed frames.
        send_frame(0, 8'hA5, 1'b0, 1'b0, '0);
        idle_cycles(0, 1);
        send_frame(1, 8'h01, 1'b0, 1'b1, 8'hFF);
        send_frame(1, 8'hFF, 1'b0, 1'b0, '0);
        idle_cycles(1, 1);

        // Reset in the 4th DATA cycle.
        valid_drv[0] = 1'b1;
        data_drv[0]  = 8'hC3;
        @(negedge tx_clk);
        valid_drv[0] = 1'b0;
        repeat (4) @(negedge tx_clk);
        #1;
        check("pre_rst_busy", busy_w[0], 1);
        rst_n = 1'b0;
        #1;
        check("midrst_line",  line_w[0],  1);
        check("midrst_busy",  busy_w[0],  0);
        check("midrst_ready", ready_w[0], 1);
        @(negedge tx_clk);
        rst_n = 1'b1;
        @(negedge tx_clk);
        send_frame(0, 8'h3C, 1'b0, 1'b0, '0);
        idle_cycles(0, 1);

        // Input data churning during the frame.
        send_frame(0, 8'h96, 1'b1, 1'b0, '0);
        send_frame(1, 8'h5A, 1'b1, 1'b0, '0);
        idle_cycles(1, 1);

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            idx = int'($urandom_range(0, 1));
            d   = DW'($urandom);
            send_frame(idx, d, 1'($urandom), 1'b0, '0);
            idle_cycles(idx, int'($urandom_range(0, 2)));
        end
        idle_cycles(0, 1);
        idle_cycles(1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
